// File: rtl/dct_mac_pkg.sv
// Shared widths, helpers and stage-1 control bundle for the dct_unit MAC pipeline.
package dct_mac_pkg;

  localparam int unsigned DEF_DWIDTH  = 8;
  localparam int unsigned DEF_CWIDTH  = 16;
  localparam int unsigned DEF_ACC_LEN = 8;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < value) r++;
    return r;
  endfunction

  // Control half of the stage-1 bundle; the product rides alongside at MWIDTH.
  typedef struct packed {
    logic first;
    logic last;
    logic vld;
  } s1_ctl_t;

endpackage

// File: rtl/dct_mac_mult.sv
// Registered signed multiplier stage; holds product and flags while stalled.
module dct_mac_mult
  import dct_mac_pkg::*;
#(
  parameter int unsigned DWIDTH = DEF_DWIDTH,
  parameter int unsigned CWIDTH = DEF_CWIDTH,
  localparam int unsigned MWIDTH = DWIDTH + CWIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic                     accept,
  input  logic                     is_first,
  input  logic                     is_last,
  input  logic signed [DWIDTH-1:0] in_data,
  input  logic signed [CWIDTH-1:0] in_coef,
  output logic signed [MWIDTH-1:0] prod,
  output s1_ctl_t                  ctl
);

  logic signed [MWIDTH-1:0] prod_c;

  // Operands are sign-extended to full product width before multiplying.
  assign prod_c = MWIDTH'(in_data) * MWIDTH'(in_coef);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod <= '0;
      ctl  <= '0;
    end else if (!stall) begin
      ctl.vld <= accept;
      if (accept) begin
        prod      <= prod_c;
        ctl.first <= is_first;
        ctl.last  <= is_last;
      end
    end
  end

endmodule

// File: rtl/dct_mac_pipe.sv
// Pipelined signed MAC: sums ACC_LEN sample*coef products per group, with
// valid/ready handshake on both sides and a mid-group restart detector.
module dct_mac_pipe
  import dct_mac_pkg::*;
#(
  parameter int unsigned DWIDTH  = DEF_DWIDTH,
  parameter int unsigned CWIDTH  = DEF_CWIDTH,
  parameter int unsigned ACC_LEN = DEF_ACC_LEN,
  localparam int unsigned MWIDTH = DWIDTH + CWIDTH,
  localparam int unsigned RWIDTH = MWIDTH + clog2(ACC_LEN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_first,
  input  logic signed [DWIDTH-1:0] in_data,
  input  logic signed [CWIDTH-1:0] in_coef,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [RWIDTH-1:0] out_data,
  output logic                     err_seq
);

  localparam int unsigned CNT_W = clog2(ACC_LEN);

  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         idx_c;
  logic [CNT_W-1:0]         cnt_nxt_c;
  logic                     stall_c;
  logic                     accept_c;
  logic                     first_c;
  logic                     last_c;
  logic                     seq_err_c;
  logic signed [MWIDTH-1:0] s1_prod;
  s1_ctl_t                  s1_ctl;
  logic signed [RWIDTH-1:0] acc;
  logic signed [RWIDTH-1:0] acc_in_c;
  logic signed [RWIDTH-1:0] sum_c;

  assign stall_c  = ~ena | (out_valid & ~out_ready);
  assign in_ready = rst_n & ~stall_c;
  assign accept_c = in_valid & in_ready;

  // in_first restarts the group: this pair becomes index 0 regardless of cnt.
  assign idx_c     = in_first ? '0 : cnt;
  assign first_c   = (idx_c == '0);
  assign last_c    = (idx_c == CNT_W'(ACC_LEN - 1));
  assign cnt_nxt_c = last_c ? '0 : idx_c + CNT_W'(1);
  assign seq_err_c = accept_c & in_first & (cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      err_seq <= 1'b0;
    end else begin
      if (accept_c) cnt <= cnt_nxt_c;
      if (ena) err_seq <= seq_err_c;
    end
  end

  dct_mac_mult #(
    .DWIDTH (DWIDTH),
    .CWIDTH (CWIDTH)
  ) u_mult (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall    (stall_c),
    .accept   (accept_c),
    .is_first (first_c),
    .is_last  (last_c),
    .in_data  (in_data),
    .in_coef  (in_coef),
    .prod     (s1_prod),
    .ctl      (s1_ctl)
  );

  assign acc_in_c = s1_ctl.first ? '0 : acc;
  assign sum_c    = acc_in_c + RWIDTH'(s1_prod);

  // Completion reloads the output in the same cycle the previous result is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (!stall_c) begin
      if (s1_ctl.vld && s1_ctl.last) begin
        out_data  <= sum_c;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
        if (s1_ctl.vld) acc <= sum_c;
      end
    end
  end

endmodule

// File: tb/tb_dct_mac_pipe.sv
// Directed self-checking bench for dct_mac_pipe at default widths (8x16, groups of 8).
module tb_dct_mac_pipe;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               ena;
  logic               in_valid;
  logic               in_ready;
  logic               in_first;
  logic signed [7:0]  in_data;
  logic signed [15:0] in_coef;
  logic               out_valid;
  logic               out_ready;
  logic signed [26:0] out_data;
  logic               err_seq;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  int err_cnt = 0;
  int err_cyc = 0;
  logic signed [26:0] res_q[$];
  int cyc_q[$];

  dct_mac_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_first  (in_first),
    .in_data   (in_data),
    .in_coef   (in_coef),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err_seq   (err_seq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output handshake and every err_seq cycle.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      res_q.push_back(out_data);
      cyc_q.push_back(cyc);
    end
    if (rst_n && err_seq) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic clear_log();
    res_q.delete();
    cyc_q.delete();
    err_cnt = 0;
  endtask

  // Offer one pair and hold it until accepted; last_acc = edge count at accept.
  task automatic send(input int d, input int c, input logic f);
    bit ok;
    int n;
    in_valid = 1'b1;
    in_data  = 8'(d);
    in_coef  = 16'(c);
    in_first = f;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end
    last_acc = cyc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; out_ready = 1'b1;
    in_valid = 1'b0; in_first = 1'b0; in_data = '0; in_coef = '0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    checks++; if (out_data !== 27'sd0) begin errors++; $display("FAIL reset_out_data: got %0d, expected 0", out_data); end
    checks++; if (err_seq !== 1'b0) begin errors++; $display("FAIL reset_err_seq: got %b, expected 0", err_seq); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b, expected 0", in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_cycles(1);
  endtask

  task automatic test_basic();
    logic signed [26:0] got;
    int t;
    clear_log();
    for (int i = 1; i <= 8; i++) send(i, 2, i == 1);
    t = last_acc;
    idle();
    wait_cycles(4);
    checks++; if (res_q.size() !== 1) begin errors++; $display("FAIL basic_count: got %0d results, expected 1", res_q.size()); end
    got = (res_q.size() > 0) ? res_q[0] : '0;
    checks++; if (got !== 27'sd72) begin errors++; $display("FAIL basic_sum: got %0d, expected 72", got); end
    t = t + 1;
    checks++; if (cyc_q.size() == 0 || cyc_q[0] !== t) begin errors++; $display("FAIL basic_latency: got cycle %0d, expected %0d", (cyc_q.size() > 0) ? cyc_q[0] : -1, t); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL basic_first_silent: got %0d err pulses, expected 0", err_cnt); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b, expected 0", out_valid); end
  endtask

  task automatic test_extremes();
    logic signed [26:0] got;
    clear_log();
    for (int i = 0; i < 8; i++) send(-128, -32768, 1'b0);
    for (int i = 0; i < 8; i++) send(127, -32768, 1'b0);
    idle();
    wait_cycles(4);
    checks++; if (res_q.size() !== 2) begin errors++; $display("FAIL max_count: got %0d results, expected 2", res_q.size()); end
    got = (res_q.size() > 0) ? res_q[0] : '0;
    checks++; if (got !== 27'sd33554432) begin errors++; $display("FAIL max_pos_sum: got %0d, expected 33554432", got); end
    got = (res_q.size() > 1) ? res_q[1] : '0;
    checks++; if (got !== -27'sd33292288) begin errors++; $display("FAIL max_neg_sum: got %0d, expected -33292288", got); end
  endtask

  task automatic test_backpressure();
    logic signed [26:0] got;
    clear_log();
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(i, 3, 1'b0);
    idle();
    wait_cycles(2);
    // Next group's first pair is offered while the result is blocked.
    in_valid = 1'b1; in_data = -8'sd1; in_coef = 16'sd5; in_first = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_hold[%0d]: got %b, expected 1", k, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b, expected 0", k, in_ready); end
      checks++; if (out_data !== 27'sd108) begin errors++; $display("FAIL bp_data_stable[%0d]: got %0d, expected 108", k, out_data); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send(-i, 5, 1'b0);
    idle();
    wait_cycles(4);
    checks++; if (res_q.size() !== 2) begin errors++; $display("FAIL bp_count: got %0d results, expected 2", res_q.size()); end
    got = (res_q.size() > 0) ? res_q[0] : '0;
    checks++; if (got !== 27'sd108) begin errors++; $display("FAIL bp_first_sum: got %0d, expected 108", got); end
    got = (res_q.size() > 1) ? res_q[1] : '0;
    checks++; if (got !== -27'sd180) begin errors++; $display("FAIL bp_next_sum: got %0d, expected -180", got); end
  endtask

  task automatic test_back_to_back();
    logic signed [26:0] got;
    int gap;
    clear_log();
    for (int i = 1; i <= 8; i++) send(i, i, 1'b0);
    for (int i = 1; i <= 8; i++) send(-i, 100, 1'b0);
    idle();
    wait_cycles(4);
    checks++; if (res_q.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d results, expected 2", res_q.size()); end
    got = (res_q.size() > 0) ? res_q[0] : '0;
    checks++; if (got !== 27'sd204) begin errors++; $display("FAIL b2b_sum0: got %0d, expected 204", got); end
    got = (res_q.size() > 1) ? res_q[1] : '0;
    checks++; if (got !== -27'sd3600) begin errors++; $display("FAIL b2b_sum1: got %0d, expected -3600", got); end
    gap = (cyc_q.size() > 1) ? cyc_q[1] - cyc_q[0] : -1;
    checks++; if (gap !== 8) begin errors++; $display("FAIL b2b_spacing: got %0d cycles, expected 8", gap); end
  endtask

  task automatic test_err_seq();
    logic signed [26:0] got;
    int t;
    clear_log();
    for (int i = 0; i < 4; i++) send(50, 7, 1'b0);
    send(1, -4, 1'b1);
    t = last_acc;
    for (int i = 2; i <= 8; i++) send(i, -4, 1'b0);
    idle();
    wait_cycles(4);
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL err_pulse_len: got %0d cycles, expected 1", err_cnt); end
    checks++; if (err_cyc !== t) begin errors++; $display("FAIL err_pulse_time: got cycle %0d, expected %0d", err_cyc, t); end
    checks++; if (res_q.size() !== 1) begin errors++; $display("FAIL err_count: got %0d results, expected 1", res_q.size()); end
    got = (res_q.size() > 0) ? res_q[0] : '0;
    checks++; if (got !== -27'sd144) begin errors++; $display("FAIL err_restart_sum: got %0d, expected -144", got); end
  endtask

  task automatic test_reset_ena();
    logic signed [26:0] got;
    clear_log();
    for (int i = 0; i < 3; i++) send(99, 99, 1'b0);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b, expected 0", out_valid); end
    checks++; if (out_data !== 27'sd0) begin errors++; $display("FAIL midrst_out_data: got %0d, expected 0", out_data); end
    checks++; if (err_seq !== 1'b0) begin errors++; $display("FAIL midrst_err_seq: got %b, expected 0", err_seq); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready: got %b, expected 0", in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) send(i, 10, 1'b0);
    // Junk offered while disabled, including a stray in_first, must be ignored.
    ena = 1'b0;
    in_valid = 1'b1; in_data = 8'sd77; in_coef = 16'sd77; in_first = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ena_in_ready[%0d]: got %b, expected 0", k, in_ready); end
      @(posedge clk); #1;
    end
    ena = 1'b1;
    for (int i = 4; i <= 8; i++) send(i, 10, 1'b0);
    idle();
    wait_cycles(4);
    checks++; if (res_q.size() !== 1) begin errors++; $display("FAIL ena_count: got %0d results, expected 1", res_q.size()); end
    got = (res_q.size() > 0) ? res_q[0] : '0;
    checks++; if (got !== 27'sd360) begin errors++; $display("FAIL ena_sum: got %0d, expected 360", got); end
    checks++; if (err_cnt !== 0) begin errors++; $display("FAIL ena_err_silent: got %0d err pulses, expected 0", err_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_backpressure();
    test_back_to_back();
    test_err_seq();
    test_reset_ena();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
